// File: rtl/idma_burst_arbiter.sv
// rtl/idma_burst_arbiter.sv - round-robin, burst-locked merge of NUM_REQ valid/ready streams
module idma_burst_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 16,
  localparam int unsigned CNT_W    = $clog2(MAX_BURST) + 1,
  localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic [ID_W-1:0]           out_id,
  input  logic                      out_ready,
  output logic                      busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]   last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  int unsigned       scan_idx;

  logic [DATA_W-1:0] req_data_arr [NUM_REQ];
  logic              cur_valid;
  logic              cur_last;
  logic              at_cap;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  assign cur_valid = req_valid[gnt_q];
  assign cur_last  = req_last[gnt_q];
  assign at_cap    = (beat_cnt_q == CNT_W'(MAX_BURST - 1));

  // Rotating-priority search: first valid requester after the previous burst owner
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_idx   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (32'(last_gnt_q) + k) % NUM_REQ;
      if (!pick_found && req_valid[ID_W'(scan_idx)]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(scan_idx);
      end
    end
  end

  // Next-state and output decode; flush overrides everything and blocks the pending beat
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    beat_cnt_d = beat_cnt_q;
    req_ready  = '0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    out_id     = '0;
    busy       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          gnt_d      = pick_id;
          beat_cnt_d = '0;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        busy             = 1'b1;
        out_id           = gnt_q;
        out_data         = req_data_arr[gnt_q];
        out_last         = cur_valid & (cur_last | at_cap);
        out_valid        = cur_valid & ~flush;
        req_ready[gnt_q] = out_ready & ~flush;
        if (out_valid && out_ready) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (out_last) begin
            last_gnt_d = gnt_q;
            beat_cnt_d = '0;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d    = S_IDLE;
      beat_cnt_d = '0;
      last_gnt_d = ID_W'(NUM_REQ - 1);
    end
  end

  // State registers; reset leaves requester 0 with top priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      last_gnt_q <= ID_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_idma_burst_arbiter.sv
// tb/tb_idma_burst_arbiter.sv - self-checking bench for idma_burst_arbiter
module tb_idma_burst_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 16;
  localparam int ID_W      = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      flush = 1'b0;
  logic                      out_ready = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_last = '0;
  logic [DATA_W-1:0]         rd_arr [NUM_REQ];
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;
  logic [ID_W-1:0]           out_id;
  logic                      busy;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign req_data[g*DATA_W +: DATA_W] = rd_arr[g];
  end

  idma_burst_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_id   (out_id),
    .out_ready(out_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Source FIFOs feeding the requesters
  logic [DATA_W-1:0] src_d [NUM_REQ][$];
  bit                src_l [NUM_REQ][$];
  bit                src_en [NUM_REQ];
  logic [NUM_REQ-1:0] pend_pop = '0;
  int                glog[$];
  int                run_beats = 0;

  function automatic logic [DATA_W-1:0] dval(int i, int s);
    return 32'hA000_0000 | (32'(i) << 16) | 32'(s);
  endfunction

  task automatic load(int i, int n);
    for (int s = 0; s < n; s++) begin
      src_d[i].push_back(dval(i, s));
      src_l[i].push_back(s == n - 1);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_en[i] && src_d[i].size() > 0) begin
        req_valid[i] = 1'b1;
        rd_arr[i]    = src_d[i][0];
        req_last[i]  = src_l[i][0];
      end else begin
        req_valid[i] = 1'b0;
        rd_arr[i]    = '0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pend_pop[i]) begin
        void'(src_d[i].pop_front());
        void'(src_l[i].pop_front());
      end
    end
    drive();
  endtask

  task automatic run_until(int n, int budget);
    int k;
    k = 0;
    while (glog.size() < n && k < budget) begin
      cycle();
      k++;
    end
    chk("burst_count_or_timeout", glog.size(), n);
  endtask

  task automatic chk_log(int idx, int id, int len);
    int e;
    e = (idx < glog.size()) ? glog[idx] : -1;
    chk("burst_id", e / 256, id);
    chk("burst_len", e % 256, len);
  endtask

  // Reference model: owner of the current burst (-1 = none), beats sent, rotating pointer
  int                 m_owner = -1;
  int                 m_beats = 0;
  int                 m_lastg = NUM_REQ - 1;
  logic               ev, el;
  logic [NUM_REQ-1:0] er;
  bit                 found;
  int                 cand;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_owner = -1;
        m_beats = 0;
        m_lastg = NUM_REQ - 1;
      end
      if (m_owner < 0) begin
        chk("busy", busy, 0);
        chk("out_valid", out_valid, 0);
        chk("req_ready", req_ready, 0);
        if (rst) begin
          chk("rst_out_last", out_last, 0);
          chk("rst_out_id", out_id, 0);
        end
        ev = 1'b0;
        el = 1'b0;
      end else begin
        ev = req_valid[m_owner] && !flush;
        el = req_valid[m_owner] && (req_last[m_owner] || m_beats == MAX_BURST - 1);
        er = (out_ready && !flush) ? (NUM_REQ'(1) << m_owner) : '0;
        chk("busy", busy, 1);
        chk("out_valid", out_valid, ev);
        chk("out_last", out_last, el);
        chk("req_ready", req_ready, er);
        chk("out_id", out_id, m_owner);
        if (ev) chk("out_data", out_data, rd_arr[m_owner]);
      end

      pend_pop = req_ready & req_valid;

      if (rst || flush) begin
        run_beats = 0;
      end else if (out_valid && out_ready) begin
        run_beats++;
        if (out_last) begin
          glog.push_back(int'(out_id) * 256 + run_beats);
          run_beats = 0;
        end
      end

      if (!rst) begin
        if (flush) begin
          m_owner = -1;
          m_beats = 0;
          m_lastg = NUM_REQ - 1;
        end else if (m_owner < 0) begin
          found = 1'b0;
          for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (m_lastg + k) % NUM_REQ;
            if (!found && req_valid[cand]) begin
              found   = 1'b1;
              m_owner = cand;
              m_beats = 0;
            end
          end
        end else if (ev && out_ready) begin
          m_beats++;
          if (el) begin
            m_lastg = m_owner;
            m_owner = -1;
            m_beats = 0;
          end
        end
      end
    end
  end

  int busy_exp [7] = '{0, 1, 1, 1, 0, 1, 1};
  int last_exp [7] = '{0, 0, 0, 1, 0, 0, 1};
  int base;

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      src_en[i] = 1'b1;
      rd_arr[i] = '0;
    end
    drive();
    repeat (2) cycle();
    chk("rst_busy_lit", busy, 0);
    chk("rst_ready_lit", req_ready, 0);

    // Lone requester 0: 3-beat burst, bubble, 2-beat burst
    load(0, 3);
    load(0, 2);
    drive();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      #1;
      chk("t1_busy", busy, busy_exp[k]);
      chk("t1_last", out_last, last_exp[k]);
      if (k == 1) begin
        chk("t1_id", out_id, 0);
        chk("t1_data0", out_data, dval(0, 0));
      end
      if (k == 3) chk("t1_data2", out_data, dval(0, 2));
      if (k == 6) chk("t1_data_b2", out_data, dval(0, 1));
      cycle();
    end
    cycle();

    // All four requesters with long streams: capped 16-beat bursts in rotation
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    base = glog.size();
    for (int i = 0; i < NUM_REQ; i++) load(i, 32);
    drive();
    run_until(base + 8, 400);
    for (int j = 0; j < 8; j++) chk_log(base + j, j % 4, 16);

    // Requester 2 with downstream stall after 3 beats
    base = glog.size();
    load(2, 8);
    drive();
    repeat (4) cycle();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("t3_ready", req_ready, 0);
      chk("t3_valid", out_valid, 1);
      chk("t3_data_hold", out_data, dval(2, 3));
      cycle();
    end
    out_ready = 1'b1;
    run_until(base + 1, 40);
    chk_log(base, 2, 8);
    chk("t3_drained", src_d[2].size(), 0);

    // Requester 1 goes quiet mid-burst while requester 0 waits
    base = glog.size();
    load(1, 6);
    drive();
    repeat (3) cycle();
    src_en[1] = 1'b0;
    load(0, 2);
    drive();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("t4_id", out_id, 1);
      chk("t4_valid", out_valid, 0);
      chk("t4_ready0", req_ready[0], 0);
      cycle();
    end
    src_en[1] = 1'b1;
    drive();
    run_until(base + 2, 60);
    chk_log(base, 1, 6);
    chk_log(base + 1, 0, 2);

    // Flush on beat 5 of requester 3
    base = glog.size();
    load(3, 10);
    drive();
    repeat (5) cycle();
    flush = 1'b1;
    @(negedge clk);
    #1;
    chk("t5_valid", out_valid, 0);
    chk("t5_ready", req_ready, 0);
    cycle();
    flush = 1'b0;
    chk("t5_not_consumed", src_d[3].size(), 6);
    for (int i = 0; i < NUM_REQ; i++) begin
      src_d[i].delete();
      src_l[i].delete();
    end
    load(3, 2);
    load(0, 2);
    drive();
    @(negedge clk);
    #1;
    chk("t5_idle", busy, 0);
    cycle();
    run_until(base + 2, 40);
    chk_log(base, 0, 2);
    chk_log(base + 1, 3, 2);

    // Reset mid-burst of requester 2 after requester 0 held the last grant
    base = glog.size();
    load(0, 2);
    drive();
    run_until(base + 1, 20);
    chk_log(base, 0, 2);
    load(2, 8);
    drive();
    repeat (4) cycle();
    rst = 1'b1;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", req_ready, 0);
    chk("t6_id", out_id, 0);
    chk("t6_last", out_last, 0);
    cycle();
    cycle();
    rst = 1'b0;
    base = glog.size();
    load(0, 2);
    load(1, 2);
    drive();
    run_until(base + 3, 60);
    chk_log(base, 0, 2);
    chk_log(base + 1, 1, 2);
    chk_log(base + 2, 2, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
